// File: rtl/demux_sched.sv
// Round-robin steering of a byte stream onto two lanes, with full-aware lane skipping,
// a stall state that pauses upstream, per-lane delivery counters and a drop pulse.
module demux_sched #(
    parameter int BW    = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [BW-1:0]    in0,
    input  logic             in0_valid,
    input  logic             full0,
    input  logic             full1,
    output logic [BW-1:0]    out0,
    output logic [BW-1:0]    out1,
    output logic             valid_out0,
    output logic             valid_out1,
    output logic             pause,
    output logic             err_drop,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

    state_t     state_reg, state_next;
    logic       ptr_reg, ptr_next;
    logic       drop_next;
    logic [1:0] send_vec;
    logic [1:0] full_vec;
    logic       both_full;

    assign full_vec  = {full1, full0};
    assign both_full = full0 & full1;

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        send_vec   = 2'b00;
        drop_next  = 1'b0;
        case (state_reg)
            STALL: begin
                // Leaving STALL is a dead cycle: anything offered now is still discarded.
                drop_next = in0_valid;
                if (!both_full) state_next = RUN;
            end
            default: begin
                if (in0_valid) begin
                    if (!full_vec[ptr_reg]) begin
                        send_vec[ptr_reg] = 1'b1;
                        ptr_next          = ~ptr_reg;
                    end else if (!full_vec[~ptr_reg]) begin
                        // Sent on the other lane, so the preferred lane stays next in line.
                        send_vec[~ptr_reg] = 1'b1;
                    end else begin
                        drop_next = 1'b1;
                    end
                end
                if (both_full)      state_next = STALL;
                else if (in0_valid) state_next = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            ptr_reg   <= 1'b0;
            err_drop  <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            err_drop  <= drop_next;
        end
    end

    assign pause = (state_reg == STALL);

    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        logic [BW-1:0]    data_reg;
        logic             valid_reg;
        logic [CNT_W-1:0] cnt_reg;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                data_reg  <= '0;
                valid_reg <= 1'b0;
                cnt_reg   <= '0;
            end else begin
                data_reg  <= send_vec[gi] ? in0 : '0;
                valid_reg <= send_vec[gi];
                if (send_vec[gi]) cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign out0       = g_lane[0].data_reg;
    assign out1       = g_lane[1].data_reg;
    assign valid_out0 = g_lane[0].valid_reg;
    assign valid_out1 = g_lane[1].valid_reg;
    assign cnt0       = g_lane[0].cnt_reg;
    assign cnt1       = g_lane[1].cnt_reg;

endmodule
